// File: rtl/cep_define.sv
// Shared PMP types: CSR address map, pmpcfg byte layout, address-match modes and access bits.
package cep_define;

  localparam int unsigned CSR_ADDR_W = 12;

  typedef enum logic [CSR_ADDR_W-1:0] {
    CSR_PMPCFG0   = 12'h3A0,
    CSR_PMPCFG1   = 12'h3A1,
    CSR_PMPCFG2   = 12'h3A2,
    CSR_PMPCFG3   = 12'h3A3,
    CSR_PMPADDR0  = 12'h3B0,
    CSR_PMPADDR15 = 12'h3BF
  } pmp_csr_e;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'd0,
    PMP_TOR   = 2'd1,
    PMP_NA4   = 2'd2,
    PMP_NAPOT = 2'd3
  } pmp_amode_e;

  // bit position of each access type within chk_acc / {X,W,R}
  typedef enum int unsigned {
    ACC_R = 0,
    ACC_W = 1,
    ACC_X = 2
  } pmp_acc_e;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_amode_e a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  typedef enum logic {
    LOG_IDLE = 1'b0,
    LOG_HELD = 1'b1
  } log_state_e;

  localparam logic [4:0] NO_MATCH_IDX = 5'h1F;

  // WARL legalisation of a written cfg byte: reserved bits zero, W without R dropped
  function automatic pmpcfg_t legalize_cfg(input logic [7:0] b);
    pmpcfg_t c;
    c      = pmpcfg_t'(b);
    c.rsvd = 2'b00;
    if (c.w && !c.r) c.w = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational address match for a single PMP entry (OFF/TOR/NA4/NAPOT).
module pmp_entry_match
  import cep_define::*;
#(
  parameter int unsigned AW = 30
) (
  input  pmp_amode_e       mode_i,
  input  logic [AW-1:0]    pmpaddr_i,
  input  logic [AW-1:0]    prev_i,
  input  logic [AW-1:0]    word_addr_i,
  output logic             match_o
);

  logic [AW-1:0] napot_mask;

  // trailing ones plus the first zero are don't-care bits of the NAPOT region
  assign napot_mask = ~(pmpaddr_i ^ (pmpaddr_i + AW'(1)));

  always_comb begin
    match_o = 1'b0;
    case (mode_i)
      PMP_TOR:   match_o = (word_addr_i >= prev_i) && (word_addr_i < pmpaddr_i);
      PMP_NA4:   match_o = (word_addr_i == pmpaddr_i);
      PMP_NAPOT: match_o = ((word_addr_i ^ pmpaddr_i) & napot_mask) == '0;
      default:   match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_checker.sv
// RISC-V PMP: pmpcfg/pmpaddr CSR storage plus a one-cycle registered access check.
// Optional violation log enabled by defining PMP_VIOLATION_LOG_EN.
module pmp_checker
  import cep_define::*;
#(
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CSR_ADDR_W-1:0] csr_addr_i,
  input  logic                  csr_we_i,
  input  logic [31:0]           csr_wdata_i,
  output logic                  csr_hit_o,
  output logic [31:0]           csr_rdata_o,
  input  logic                  chk_valid_i,
  input  logic [ADDR_W-1:0]     chk_addr_i,
  input  logic [2:0]            chk_acc_i,
  input  logic                  chk_priv_m_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_fault_o,
  output logic [4:0]            rsp_idx_o
`ifdef PMP_VIOLATION_LOG_EN
  ,
  input  logic                  log_clear_i,
  output logic                  log_valid_o,
  output logic [ADDR_W-1:0]     log_addr_o,
  output logic [2:0]            log_acc_o
`endif
);

  localparam int unsigned AW    = ADDR_W - 2;
  localparam int unsigned N_CFG = N_ENTRIES / 4;
  localparam logic [CSR_ADDR_W-1:0] CFG_BASE  = CSR_ADDR_W'(CSR_PMPCFG0);
  localparam logic [CSR_ADDR_W-1:0] ADDR_BASE = CSR_ADDR_W'(CSR_PMPADDR0);

  pmpcfg_t       cfg_q  [N_ENTRIES];
  pmpcfg_t       cfg_d  [N_ENTRIES];
  logic [AW-1:0] addr_q [N_ENTRIES];
  logic [AW-1:0] addr_d [N_ENTRIES];
  logic [AW-1:0] prev   [N_ENTRIES];
  logic [N_ENTRIES-1:0] match;
  logic [N_ENTRIES-1:0] addr_lock;

  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_fault_q, rsp_fault_d;
  logic [4:0] rsp_idx_q,   rsp_idx_d;

  logic       cfg_hit, addr_hit;
  logic [1:0] cfg_k;
  logic [3:0] addr_k;
  logic [AW-1:0] word_addr;
  logic       unused_byte_lsb;

  assign cfg_k     = csr_addr_i[1:0];
  assign addr_k    = csr_addr_i[3:0];
  assign cfg_hit   = (csr_addr_i[11:2] == CFG_BASE[11:2]) && (32'(cfg_k) < N_CFG);
  assign addr_hit  = (csr_addr_i[11:4] == ADDR_BASE[11:4]) && (32'(addr_k) < N_ENTRIES);
  assign csr_hit_o = cfg_hit || addr_hit;
  assign word_addr = chk_addr_i[ADDR_W-1:2];
  assign unused_byte_lsb = ^chk_addr_i[1:0];

  // CSR read mux
  always_comb begin
    csr_rdata_o = '0;
    for (int i = 0; i < int'(N_ENTRIES); i++) begin
      if (cfg_hit && cfg_k == 2'(i / 4)) csr_rdata_o[8*(i%4) +: 8] = cfg_q[i];
      if (addr_hit && addr_k == 4'(i))   csr_rdata_o = 32'(addr_q[i]);
    end
  end

  // a pmpaddr is frozen by its own lock or by a locked TOR entry above it
  always_comb begin
    addr_lock = '0;
    for (int i = 0; i < int'(N_ENTRIES) - 1; i++)
      addr_lock[i] = cfg_q[i+1].l && (cfg_q[i+1].a == PMP_TOR);
    for (int i = 0; i < int'(N_ENTRIES); i++)
      addr_lock[i] = addr_lock[i] || cfg_q[i].l;
  end

  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    for (int i = 0; i < int'(N_ENTRIES); i++) begin
      if (csr_we_i && cfg_hit && cfg_k == 2'(i / 4) && !cfg_q[i].l)
        cfg_d[i] = legalize_cfg(csr_wdata_i[8*(i%4) +: 8]);
      if (csr_we_i && addr_hit && addr_k == 4'(i) && !addr_lock[i])
        addr_d[i] = csr_wdata_i[AW-1:0];
    end
  end

  for (genvar g = 0; g < int'(N_ENTRIES); g++) begin : g_entry
    if (g == 0) begin : g_first
      assign prev[g] = '0;
    end else begin : g_rest
      assign prev[g] = addr_q[g-1];
    end
    pmp_entry_match #(.AW(AW)) u_match (
      .mode_i      (cfg_q[g].a),
      .pmpaddr_i   (addr_q[g]),
      .prev_i      (prev[g]),
      .word_addr_i (word_addr),
      .match_o     (match[g])
    );
  end

  // priority select and permission evaluation
  always_comb begin
    logic       hit_found;
    logic [4:0] hit_idx;
    pmpcfg_t    hit_cfg;
    logic [2:0] perm;
    logic       acc_ok;
    logic       fault;
    logic [4:0] idx;

    hit_found = 1'b0;
    hit_idx   = NO_MATCH_IDX;
    hit_cfg   = '0;
    for (int i = int'(N_ENTRIES) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_found = 1'b1;
        hit_idx   = 5'(i);
        hit_cfg   = cfg_q[i];
      end
    end
    perm   = {hit_cfg.x, hit_cfg.w, hit_cfg.r};
    acc_ok = (chk_acc_i != 3'b000) && ((chk_acc_i & (chk_acc_i - 3'd1)) == 3'b000);

    if (!acc_ok) begin
      fault = 1'b1;
      idx   = NO_MATCH_IDX;
    end else if (!hit_found) begin
      fault = !chk_priv_m_i;
      idx   = NO_MATCH_IDX;
    end else begin
      fault = (chk_priv_m_i && !hit_cfg.l) ? 1'b0 : ~|(perm & chk_acc_i);
      idx   = hit_idx;
    end

    rsp_valid_d = chk_valid_i;
    rsp_fault_d = chk_valid_i ? fault : rsp_fault_q;
    rsp_idx_d   = chk_valid_i ? idx   : rsp_idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_ENTRIES); i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_idx_q   <= NO_MATCH_IDX;
    end else begin
      cfg_q       <= cfg_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_idx_q   <= rsp_idx_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_fault_o = rsp_fault_q;
  assign rsp_idx_o   = rsp_idx_q;

`ifdef PMP_VIOLATION_LOG_EN
  log_state_e        log_state_q, log_state_d;
  logic [ADDR_W-1:0] log_addr_q,  log_addr_d;
  logic [2:0]        log_acc_q,   log_acc_d;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [2:0]        rsp_acc_q;

  // first fault is held until cleared; clear beats a coincident fault
  always_comb begin
    log_state_d = log_state_q;
    log_addr_d  = log_addr_q;
    log_acc_d   = log_acc_q;
    case (log_state_q)
      LOG_IDLE: begin
        if (!log_clear_i && rsp_valid_q && rsp_fault_q) begin
          log_state_d = LOG_HELD;
          log_addr_d  = rsp_addr_q;
          log_acc_d   = rsp_acc_q;
        end
      end
      LOG_HELD: begin
        if (log_clear_i) begin
          log_state_d = LOG_IDLE;
          log_addr_d  = '0;
          log_acc_d   = '0;
        end
      end
      default: log_state_d = LOG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      log_state_q <= LOG_IDLE;
      log_addr_q  <= '0;
      log_acc_q   <= '0;
      rsp_addr_q  <= '0;
      rsp_acc_q   <= '0;
    end else begin
      log_state_q <= log_state_d;
      log_addr_q  <= log_addr_d;
      log_acc_q   <= log_acc_d;
      if (chk_valid_i) begin
        rsp_addr_q <= chk_addr_i;
        rsp_acc_q  <= chk_acc_i;
      end
    end
  end

  assign log_valid_o = (log_state_q == LOG_HELD);
  assign log_addr_o  = log_addr_q;
  assign log_acc_o   = log_acc_q;
`endif

endmodule

// File: tb/tb_pmp_checker.sv
// Directed self-checking bench for pmp_checker (8 entries, 32-bit addresses).
module tb_pmp_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        csr_hit;
  logic [31:0] csr_rdata;
  logic        chk_valid;
  logic [31:0] chk_addr;
  logic [2:0]  chk_acc;
  logic        chk_priv_m;
  logic        rsp_valid;
  logic        rsp_fault;
  logic [4:0]  rsp_idx;
`ifdef PMP_VIOLATION_LOG_EN
  logic        log_clear;
  logic        log_valid;
  logic [31:0] log_addr;
  logic [2:0]  log_acc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pmp_checker #(.N_ENTRIES(8), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_addr_i   (csr_addr),
    .csr_we_i     (csr_we),
    .csr_wdata_i  (csr_wdata),
    .csr_hit_o    (csr_hit),
    .csr_rdata_o  (csr_rdata),
    .chk_valid_i  (chk_valid),
    .chk_addr_i   (chk_addr),
    .chk_acc_i    (chk_acc),
    .chk_priv_m_i (chk_priv_m),
    .rsp_valid_o  (rsp_valid),
    .rsp_fault_o  (rsp_fault),
    .rsp_idx_o    (rsp_idx)
`ifdef PMP_VIOLATION_LOG_EN
    ,
    .log_clear_i  (log_clear),
    .log_valid_o  (log_valid),
    .log_addr_o   (log_addr),
    .log_acc_o    (log_acc)
`endif
  );

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] W = 3'b010;
  localparam logic [2:0] X = 3'b100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_we    = 1'b1;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a, input logic hit, input logic [31:0] d);
    csr_addr = a;
    #1;
    check({tag, ".hit"}, 32'(csr_hit), 32'(hit));
    check({tag, ".rdata"}, csr_rdata, d);
  endtask

  task automatic chk(input string tag, input logic [31:0] a, input logic [2:0] acc,
                     input logic m, input logic fault, input logic [4:0] idx);
    chk_addr   = a;
    chk_acc    = acc;
    chk_priv_m = m;
    chk_valid  = 1'b1;
    tick();
    chk_valid  = 1'b0;
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".fault"}, 32'(rsp_fault), 32'(fault));
    check({tag, ".idx"},   32'(rsp_idx),   32'(idx));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    csr_addr   = '0;
    csr_we     = 1'b0;
    csr_wdata  = '0;
    chk_valid  = 1'b0;
    chk_addr   = '0;
    chk_acc    = R;
    chk_priv_m = 1'b0;
`ifdef PMP_VIOLATION_LOG_EN
    log_clear  = 1'b0;
`endif
    repeat (3) tick();
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.fault", 32'(rsp_fault), 32'd0);
    check("rst.idx",   32'(rsp_idx),   32'h1F);
    rst_n = 1'b1;
    tick();

    csr_rd("rd_cfg0",   12'h3A0, 1'b1, 32'h0);
    csr_rd("rd_addr0",  12'h3B0, 1'b1, 32'h0);
    csr_rd("rd_cfg1",   12'h3A1, 1'b1, 32'h0);
    csr_rd("rd_cfg3",   12'h3A3, 1'b0, 32'h0);
    csr_rd("rd_addr8",  12'h3B8, 1'b0, 32'h0);

    // entry 0: TOR [0, 0x1000) RWX
    csr_wr(12'h3B0, 32'h0000_0400);
    csr_wr(12'h3A0, 32'h0000_000F);
    csr_rd("cfg0_tor", 12'h3A0, 1'b1, 32'h0000_000F);
    chk("tor_in",  32'h0000_0FFC, R, 1'b0, 1'b0, 5'd0);
    chk("tor_out", 32'h0000_1000, R, 1'b0, 1'b1, 5'h1F);
    tick();
    check("hold.valid", 32'(rsp_valid), 32'd0);
    check("hold.fault", 32'(rsp_fault), 32'd1);
    check("hold.idx",   32'(rsp_idx),   32'h1F);

    // entry 1: NAPOT 16 KiB at 0, read-only
    csr_wr(12'h3B1, 32'h0000_07FF);
    csr_wr(12'h3A0, 32'h0000_190F);
    csr_rd("cfg0_napot", 12'h3A0, 1'b1, 32'h0000_190F);
    chk("napot_w",  32'h0000_3FFC, W, 1'b0, 1'b1, 5'd1);
    chk("napot_r",  32'h0000_3FFC, R, 1'b0, 1'b0, 5'd1);
    chk("napot_out", 32'h0000_4000, R, 1'b0, 1'b1, 5'h1F);
    chk("prio",     32'h0000_0100, W, 1'b0, 1'b0, 5'd0);

    // reserved bits cleared, W without R dropped
    csr_wr(12'h3A0, 32'h006A_190F);
    csr_rd("cfg0_warl", 12'h3A0, 1'b1, 32'h0008_190F);

    // lock entry 0 as TOR with R,X
    csr_wr(12'h3A0, 32'h0008_198D);
    csr_rd("cfg0_lock", 12'h3A0, 1'b1, 32'h0008_198D);
    csr_wr(12'h3A0, 32'h0008_190F);
    csr_rd("cfg0_locked", 12'h3A0, 1'b1, 32'h0008_198D);
    csr_wr(12'h3B0, 32'h0000_0000);
    csr_rd("addr0_locked", 12'h3B0, 1'b1, 32'h0000_0400);
    chk("m_lock_w",   32'h0000_0100, W, 1'b1, 1'b1, 5'd0);
    chk("m_lock_r",   32'h0000_0100, R, 1'b1, 1'b0, 5'd0);
    chk("m_lock_x",   32'h0000_0100, X, 1'b1, 1'b0, 5'd0);
    chk("m_nomatch",  32'h0000_8000, R, 1'b1, 1'b0, 5'h1F);
    chk("u_nomatch",  32'h0000_8000, R, 1'b0, 1'b1, 5'h1F);
    chk("acc_multi",  32'h0000_0100, 3'b011, 1'b1, 1'b1, 5'h1F);
    chk("acc_zero",   32'h0000_0100, 3'b000, 1'b1, 1'b1, 5'h1F);

    // entry 3: NA4 at 0x8000, no permissions
    csr_wr(12'h3B3, 32'h0000_2000);
    csr_wr(12'h3A0, 32'h1008_198D);
    chk("na4_none", 32'h0000_8000, R, 1'b0, 1'b1, 5'd3);
    chk("na4_next", 32'h0000_8004, R, 1'b0, 1'b1, 5'h1F);

    // CSR write and check in the same cycle: old permissions apply
    csr_addr   = 12'h3A0;
    csr_wdata  = 32'h1108_198D;
    csr_we     = 1'b1;
    chk_addr   = 32'h0000_8000;
    chk_acc    = R;
    chk_priv_m = 1'b0;
    chk_valid  = 1'b1;
    tick();
    csr_we     = 1'b0;
    chk_valid  = 1'b0;
    check("samecyc.fault", 32'(rsp_fault), 32'd1);
    check("samecyc.idx",   32'(rsp_idx),   32'd3);
    chk("na4_newperm", 32'h0000_8000, R, 1'b0, 1'b0, 5'd3);

    // reset with a request in flight
    chk_addr   = 32'h0000_8000;
    chk_acc    = R;
    chk_valid  = 1'b1;
    rst_n      = 1'b0;
    tick();
    chk_valid  = 1'b0;
    check("rst_mid.valid", 32'(rsp_valid), 32'd0);
    check("rst_mid.fault", 32'(rsp_fault), 32'd0);
    check("rst_mid.idx",   32'(rsp_idx),   32'h1F);
    rst_n = 1'b1;
    tick();
    csr_rd("rst_cfg0",  12'h3A0, 1'b1, 32'h0);
    csr_rd("rst_addr0", 12'h3B0, 1'b1, 32'h0);
    csr_wr(12'h3A0, 32'h0000_000F);
    csr_rd("unlocked_cfg0", 12'h3A0, 1'b1, 32'h0000_000F);

`ifdef PMP_VIOLATION_LOG_EN
    check("log.idle", 32'(log_valid), 32'd0);
    chk("log_f1", 32'h0000_0100, R, 1'b0, 1'b1, 5'h1F);
    chk("log_f2", 32'h0000_0200, W, 1'b0, 1'b1, 5'h1F);
    tick();
    check("log.valid", 32'(log_valid), 32'd1);
    check("log.addr",  log_addr,       32'h0000_0100);
    check("log.acc",   32'(log_acc),   32'(R));
    log_clear = 1'b1;
    tick();
    log_clear = 1'b0;
    check("log.clear", 32'(log_valid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
